// File: rtl/alu_branch_unit_pkg.sv
// Shared encodings for the execute stage: ALU op codes, RV32I opcodes,
// branch funct3 values and next-PC source selects.
package alu_branch_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned ALU_FUN_W = 4;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned PC_SRC_W  = 3;

  typedef enum logic [ALU_FUN_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_e;

  typedef enum logic [OPCODE_W-1:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [FUNCT3_W-1:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SRC_SEQ    = 3'd0,
    PC_SRC_JALR   = 3'd1,
    PC_SRC_BRANCH = 3'd2,
    PC_SRC_JAL    = 3'd3
  } pc_src_e;

endpackage

// File: rtl/alu_branch_unit_alu_core.sv
// Operand selection and the integer ALU; purely combinational.
module alu_core
  import alu_branch_unit_pkg::*;
(
  input  logic [XLEN-1:0]      rs1,
  input  logic [XLEN-1:0]      rs2,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic                 alu_src_a,
  input  logic [1:0]           alu_src_b,
  input  logic [ALU_FUN_W-1:0] alu_fun,
  output logic [XLEN-1:0]      alu_result
);

  logic [XLEN-1:0]    src_a;
  logic [XLEN-1:0]    src_b;
  logic [SHAMT_W-1:0] shamt;

  always_comb begin
    src_a = alu_src_a ? imm : rs1;
    unique case (alu_src_b)
      2'd0:    src_b = rs2;
      2'd1:    src_b = imm;
      2'd2:    src_b = imm;
      default: src_b = pc;
    endcase
    shamt = src_b[SHAMT_W-1:0];
  end

  // Undefined op codes deliberately produce zero.
  always_comb begin
    alu_result = '0;
    case (alu_fun)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLTU: alu_result = XLEN'(src_a < src_b);
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(src_a) >>> shamt);
      ALU_OR:   alu_result = src_a | src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_LUI:  alu_result = src_a;
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// Execute-stage ALU with branch condition/target generation, next-PC select
// and a stallable result register.
module alu_branch_unit
  import alu_branch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      rs1,
  input  logic [XLEN-1:0]      rs2,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic                 alu_src_a,
  input  logic [1:0]           alu_src_b,
  input  logic [ALU_FUN_W-1:0] alu_fun,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic                 flush,
  input  logic                 stall,
  output logic [XLEN-1:0]      alu_result,
  output logic [XLEN-1:0]      jalr,
  output logic [XLEN-1:0]      branch,
  output logic [XLEN-1:0]      jal,
  output logic                 br_eq,
  output logic                 br_lt,
  output logic                 br_ltu,
  output logic [PC_SRC_W-1:0]  pc_source,
  output logic [XLEN-1:0]      result_q,
  output logic                 valid_q
);

  logic [XLEN-1:0] jalr_sum;
  logic            taken;
  pc_src_e         pc_sel;
  logic [XLEN-1:0] result_d;
  logic            valid_d;

  alu_core u_alu_core (
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .pc         (pc),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_fun    (alu_fun),
    .alu_result (alu_result)
  );

  // Comparisons always use the raw forwarded operands, not the ALU muxes.
  assign br_eq  = (rs1 == rs2);
  assign br_lt  = ($signed(rs1) < $signed(rs2));
  assign br_ltu = (rs1 < rs2);

  assign jalr_sum = rs1 + imm;
  assign jalr     = {jalr_sum[XLEN-1:1], 1'b0};
  assign branch   = pc + imm;
  assign jal      = pc + imm;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = br_eq;
      F3_BNE:  taken = !br_eq;
      F3_BLT:  taken = br_lt;
      F3_BGE:  taken = !br_lt;
      F3_BLTU: taken = br_ltu;
      F3_BGEU: taken = !br_ltu;
      default: taken = 1'b0;
    endcase
  end

  // A squashed instruction must never redirect fetch.
  always_comb begin
    pc_sel = PC_SRC_SEQ;
    if (!flush) begin
      case (opcode)
        OPC_JAL:    pc_sel = PC_SRC_JAL;
        OPC_JALR:   pc_sel = PC_SRC_JALR;
        OPC_BRANCH: pc_sel = taken ? PC_SRC_BRANCH : PC_SRC_SEQ;
        default:    pc_sel = PC_SRC_SEQ;
      endcase
    end
  end

  assign pc_source = pc_sel;

  // Stall has priority over flush: the register simply holds.
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    if (!stall) begin
      result_d = alu_result;
      valid_d  = !flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Self-checking bench for alu_branch_unit: directed corner cases plus
// randomized stimulus against an arithmetic reference model.
module tb_alu_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rs1, rs2, imm, pc;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_fun;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        flush, stall;
  logic [31:0] alu_result, jalr, branch, jal, result_q;
  logic        br_eq, br_lt, br_ltu, valid_q;
  logic [2:0]  pc_source;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_fun(alu_fun),
    .opcode(opcode), .funct3(funct3), .flush(flush), .stall(stall),
    .alu_result(alu_result), .jalr(jalr), .branch(branch), .jal(jal),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .pc_source(pc_source),
    .result_q(result_q), .valid_q(valid_q)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_src_a(input logic sa, input logic [31:0] r1, input logic [31:0] im);
    return sa ? im : r1;
  endfunction

  function automatic logic [31:0] m_src_b(input logic [1:0] sb, input logic [31:0] r2,
                                          input logic [31:0] im, input logic [31:0] p);
    if (sb == 2'd0) return r2;
    if (sb == 2'd3) return p;
    return im;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1001: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return int'(a) < int'(b);
      3'b101: return int'(a) >= int'(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] m_pcsrc(input logic fl, input logic [6:0] op, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    if (fl) return 3'd0;
    if (op == 7'b1101111) return 3'd3;
    if (op == 7'b1100111) return 3'd1;
    if (op == 7'b1100011 && m_taken(f3, a, b)) return 3'd2;
    return 3'd0;
  endfunction

  task automatic drive_idle();
    rs1 = 0; rs2 = 0; imm = 0; pc = 0; alu_src_a = 0; alu_src_b = 0;
    alu_fun = 0; opcode = 7'b0110011; funct3 = 0; flush = 0; stall = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    rs1 = 32'd3; rs2 = 32'd4;
    #2;
    n_checks++;
    if (result_q !== 32'd0 || valid_q !== 1'b0)
      $display("FAIL reset_state: result_q=%h valid_q=%b expected 0/0", result_q, valid_q);
    else n_pass++;
    n_checks++;
    if (alu_result !== 32'd7)
      $display("FAIL comb_in_reset: alu_result=%h expected 00000007", alu_result);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (result_q !== 32'd0 || valid_q !== 1'b0)
      $display("FAIL reset_held: result_q=%h valid_q=%b expected 0/0", result_q, valid_q);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_directed();
    drive_idle();
    rs1 = 32'h7FFFFFFF; rs2 = 32'd1; alu_fun = 4'b0000; #1;
    n_checks++;
    if (alu_result !== 32'h80000000) $display("FAIL add_wrap: got %h expected 80000000", alu_result);
    else n_pass++;
    alu_fun = 4'b0010; #1;
    n_checks++;
    if (alu_result !== 32'd0) $display("FAIL slt_pos: got %h expected 00000000", alu_result);
    else n_pass++;
    rs1 = 32'd0; alu_fun = 4'b1000; #1;
    n_checks++;
    if (alu_result !== 32'hFFFFFFFF) $display("FAIL sub_wrap: got %h expected ffffffff", alu_result);
    else n_pass++;
    rs1 = 32'h80000000; imm = 32'h24; alu_src_b = 2'd1; alu_fun = 4'b1101; #1;
    n_checks++;
    if (alu_result !== 32'hF8000000) $display("FAIL sra_imm: got %h expected f8000000", alu_result);
    else n_pass++;
    alu_fun = 4'b0101; #1;
    n_checks++;
    if (alu_result !== 32'h08000000) $display("FAIL srl_imm: got %h expected 08000000", alu_result);
    else n_pass++;
    alu_fun = 4'b1111; #1;
    n_checks++;
    if (alu_result !== 32'd0) $display("FAIL undefined_op: got %h expected 00000000", alu_result);
    else n_pass++;
  endtask

  task automatic test_branch_directed();
    drive_idle();
    rs1 = 32'hFFFFFFFF; rs2 = 32'd1; pc = 32'h200; imm = 32'h40;
    opcode = 7'b1100011; funct3 = 3'b100; #1;
    n_checks++;
    if ({br_eq, br_lt, br_ltu} !== 3'b010)
      $display("FAIL bcg_flags: got eq/lt/ltu=%b expected 010", {br_eq, br_lt, br_ltu});
    else n_pass++;
    n_checks++;
    if (pc_source !== 3'd2 || branch !== 32'h240)
      $display("FAIL blt_taken: pc_source=%0d branch=%h expected 2/00000240", pc_source, branch);
    else n_pass++;
    funct3 = 3'b110; #1;
    n_checks++;
    if (pc_source !== 3'd0) $display("FAIL bltu_not_taken: got %0d expected 0", pc_source);
    else n_pass++;
    funct3 = 3'b010; rs2 = rs1; #1;
    n_checks++;
    if (pc_source !== 3'd0) $display("FAIL f3_010_never: got %0d expected 0", pc_source);
    else n_pass++;
  endtask

  task automatic test_jump_directed();
    drive_idle();
    opcode = 7'b1100111; rs1 = 32'h1001; imm = 32'h4; #1;
    n_checks++;
    if (jalr !== 32'h1004 || pc_source !== 3'd1)
      $display("FAIL jalr: target=%h pc_source=%0d expected 00001004/1", jalr, pc_source);
    else n_pass++;
    flush = 1'b1; #1;
    n_checks++;
    if (pc_source !== 3'd0 || jalr !== 32'h1004)
      $display("FAIL jalr_flush: pc_source=%0d target=%h expected 0/00001004", pc_source, jalr);
    else n_pass++;
    flush = 1'b0; opcode = 7'b1101111; pc = 32'h100; imm = 32'hFFFFFFF0; #1;
    n_checks++;
    if (jal !== 32'hF0 || pc_source !== 3'd3)
      $display("FAIL jal: target=%h pc_source=%0d expected 000000f0/3", jal, pc_source);
    else n_pass++;
  endtask

  task automatic test_random_comb();
    logic [6:0]  ops [5];
    logic [31:0] a, b, exp_alu, exp_jalr;
    logic [2:0]  exp_pcs;
    int          n_bad;
    ops[0] = 7'b1100011; ops[1] = 7'b1100111; ops[2] = 7'b1101111;
    ops[3] = 7'b0110011; ops[4] = 7'b0110111;
    n_bad = 0;
    for (int i = 0; i < 300; i++) begin
      rs1 = $urandom; rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      imm = $urandom; pc = $urandom;
      alu_src_a = 1'($urandom); alu_src_b = 2'($urandom); alu_fun = 4'($urandom);
      opcode = (i % 2 == 0) ? ops[$urandom_range(0, 4)] : 7'($urandom);
      funct3 = 3'($urandom); flush = ($urandom_range(0, 4) == 0);
      #1;
      a = m_src_a(alu_src_a, rs1, imm);
      b = m_src_b(alu_src_b, rs2, imm, pc);
      exp_alu  = m_alu(alu_fun, a, b);
      exp_jalr = (rs1 + imm) & ~32'd1;
      exp_pcs  = m_pcsrc(flush, opcode, funct3, rs1, rs2);
      n_checks++;
      if (alu_result !== exp_alu) begin
        n_bad++;
        $display("FAIL rand_alu[%0d]: fun=%b a=%h b=%h got %h expected %h", i, alu_fun, a, b, alu_result, exp_alu);
      end else n_pass++;
      n_checks++;
      if ({br_eq, br_lt, br_ltu} !== {rs1 == rs2, int'(rs1) < int'(rs2), rs1 < rs2}) begin
        n_bad++;
        $display("FAIL rand_bcg[%0d]: rs1=%h rs2=%h got %b", i, rs1, rs2, {br_eq, br_lt, br_ltu});
      end else n_pass++;
      n_checks++;
      if (jalr !== exp_jalr || branch !== pc + imm || jal !== pc + imm) begin
        n_bad++;
        $display("FAIL rand_targets[%0d]: jalr=%h branch=%h jal=%h expected %h/%h", i, jalr, branch, jal, exp_jalr, pc + imm);
      end else n_pass++;
      n_checks++;
      if (pc_source !== exp_pcs) begin
        n_bad++;
        $display("FAIL rand_pcsrc[%0d]: op=%b f3=%b fl=%b got %0d expected %0d", i, opcode, funct3, flush, pc_source, exp_pcs);
      end else n_pass++;
      if (n_bad > 20) break;
    end
  endtask

  task automatic test_register();
    drive_idle();
    @(negedge clk);
    rs1 = 32'd2; rs2 = 32'd3; alu_fun = 4'b0000;
    @(posedge clk); #1;
    n_checks++;
    if (result_q !== 32'd5 || valid_q !== 1'b1)
      $display("FAIL reg_load: result_q=%h valid_q=%b expected 00000005/1", result_q, valid_q);
    else n_pass++;
    @(negedge clk);
    stall = 1'b1; flush = 1'b1; rs1 = 32'd6;
    @(posedge clk); #1;
    n_checks++;
    if (result_q !== 32'd5 || valid_q !== 1'b1)
      $display("FAIL reg_stall_wins: result_q=%h valid_q=%b expected 00000005/1", result_q, valid_q);
    else n_pass++;
    @(negedge clk);
    stall = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (result_q !== 32'd9 || valid_q !== 1'b0)
      $display("FAIL reg_flush: result_q=%h valid_q=%b expected 00000009/0", result_q, valid_q);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; rs1 = 32'd2;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    n_checks++;
    if (result_q !== 32'd0 || valid_q !== 1'b0)
      $display("FAIL async_reset: result_q=%h valid_q=%b expected 0/0", result_q, valid_q);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random_reg();
    logic [31:0] exp_r;
    logic        exp_v;
    exp_r = 32'd0; exp_v = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      rs1 = $urandom; rs2 = $urandom; imm = $urandom; pc = $urandom;
      alu_src_a = 1'($urandom); alu_src_b = 2'($urandom); alu_fun = 4'($urandom);
      opcode = 7'($urandom); funct3 = 3'($urandom);
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 3) == 0);
      if (!stall) begin
        exp_r = m_alu(alu_fun, m_src_a(alu_src_a, rs1, imm), m_src_b(alu_src_b, rs2, imm, pc));
        exp_v = !flush;
      end
      @(negedge clk);
      n_checks++;
      if (result_q !== exp_r || valid_q !== exp_v)
        $display("FAIL rand_reg[%0d]: result_q=%h valid_q=%b expected %h/%b", i, result_q, valid_q, exp_r, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_branch_directed();
    test_jump_directed();
    test_random_comb();
    test_register();
    test_random_reg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_branch_unit.md
ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 RS1  input  32  forwarded rs1 operand.
REQ-004 RS2  input  32  forwarded rs2 operand.
REQ-005 IMM  input  32  decoded immediate (U/I/S/B/J already sign-extended by decode).
REQ-006 PC  input  32  address of the instruction in execute.
REQ-007 ALU_SRC_A  input  1  0 = RS1, 1 = IMM.
REQ-008 ALU_SRC_B  input  2  0 = RS2, 1 = IMM, 2 = IMM, 3 = PC.
REQ-009 ALU_FUN  input  4  operation code (REQ-016).
REQ-010 OPCODE  input  7  RV32I opcode of the instruction in execute.
REQ-011 FUNCT3  input  3  instr[14:12].
REQ-012 FLUSH  input  1  instruction in execute is squashed.
REQ-013 STALL  input  1  hold the result register.
REQ-014 ALU_RESULT  output  32  combinational ALU result; JALR/BRANCH/JAL  output  32 each  combinational target addresses; BR_EQ/BR_LT/BR_LTU  output  1 each; PC_SOURCE  output  3.
REQ-015 RESULT_Q  output  32  registered ALU result; VALID_Q  output  1  registered "result belongs to a non-flushed instruction".

Function
REQ-016 ALU ops on SRC_A op SRC_B: 0000 add; 1000 sub; 0001 sll; 0010 slt (signed, result 1/0); 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and; 1001 pass SRC_A (LUI); all other codes result 0.
REQ-017 Add/sub wrap modulo 2^32, no overflow flag; shift amount = SRC_B[4:0] only.
REQ-018 BCG: BR_EQ = (RS1 == RS2); BR_LT = signed RS1 < RS2; BR_LTU = unsigned RS1 < RS2; always from RS1/RS2, never from mux outputs.
REQ-019 BAG: JAL = PC + IMM; BRANCH = PC + IMM; JALR = (RS1 + IMM) with bit 0 forced to 0; all modulo 2^32.
REQ-020 PC_SOURCE: 0 = sequential, 1 = JALR, 2 = BRANCH, 3 = JAL; values 4-7 never driven.
REQ-021 OPCODE 1101111 -> 3; 1100111 -> 1; 1100011 -> 2 if taken else 0; any other opcode -> 0.
REQ-022 Branch taken by FUNCT3: 000 BR_EQ; 001 !BR_EQ; 100 BR_LT; 101 !BR_LT; 110 BR_LTU; 111 !BR_LTU; 010/011 never taken.
REQ-023 FLUSH = 1 forces PC_SOURCE = 0 regardless of opcode/comparison; ALU_RESULT and targets remain computed.
REQ-024 All outputs except RESULT_Q/VALID_Q are purely combinational (zero latency).
REQ-025 On each rising edge with RST high: STALL = 1 -> RESULT_Q and VALID_Q hold; else RESULT_Q <= ALU_RESULT, VALID_Q <= !FLUSH.
REQ-026 STALL and FLUSH together: STALL wins (register holds).

Reset
REQ-027 RST low asynchronously clears RESULT_Q = 0 and VALID_Q = 0, independent of CLK.
REQ-028 Release of RST takes effect at next rising edge; combinational outputs unaffected by RST.

Structure
REQ-029 ALU_FUN codes, opcode values (JAL, JALR, BRANCH, LUI, ...) and PC_SOURCE encodings live as typedef enums in a shared package used by decode, PC and this block.
REQ-030 One sub-module, alu_core (operand muxes plus REQ-016), instantiated once; BCG, BAG, PC_SOURCE decode and result register stay in the top.

Verification
REQ-031 SRC_A=RS1=0x7FFFFFFF, SRC_B=RS2=1, ALU_FUN=0000 -> ALU_RESULT=0x80000000; ALU_FUN=0010 -> 0; ALU_FUN=1000 with RS1=0, RS2=1 -> 0xFFFFFFFF.
REQ-032 RS1=0x80000000, IMM=0x24, ALU_SRC_B=1: ALU_FUN=1101 -> 0xF8000000 (shamt 4); ALU_FUN=0101 -> 0x08000000.
REQ-033 RS1=0xFFFFFFFF, RS2=1: BR_EQ=0, BR_LT=1, BR_LTU=0; OPCODE=1100011, FUNCT3=100 -> PC_SOURCE=2, BRANCH=PC+IMM; FUNCT3=110 -> 0.
REQ-034 OPCODE=1100111, RS1=0x1001, IMM=0x4 -> JALR=0x1004, PC_SOURCE=1; same with FLUSH=1 -> PC_SOURCE=0.
REQ-035 PC=0x100, IMM=0xFFFFFFF0, OPCODE=1101111 -> JAL=0xF0, PC_SOURCE=3.
REQ-036 Register: ALU_RESULT=5, edge -> RESULT_Q=5, VALID_Q=1; STALL=1 with ALU_RESULT=9 -> stays 5; RST low mid-cycle -> RESULT_Q=0, VALID_Q=0 immediately.
